vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with pixel-source handshake. It replaces the fixed 640x480, 1-bit-colour scan logic with configurable timing, sync polarity, pixel-clock division, colour depth and pixel-source latency compensation. It sits between the system clock and the VGA pins. It requests pixels from a frame buffer or pattern source and drives syncs and colour aligned to the returned data.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing types, 640x480@60 defaults and total-length helpers for the VGA
// raster generator.
package vga_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned front;
      int unsigned sync;
      int unsigned back;
   } vga_timing_t;

   localparam vga_timing_t VGA_640X480_H = '{active: 640, front: 16, sync: 96, back: 48};
   localparam vga_timing_t VGA_640X480_V = '{active: 480, front: 10, sync: 2, back: 33};

   function automatic int unsigned h_total(vga_timing_t t);
      return t.active + t.front + t.sync + t.back;
   endfunction

   function automatic int unsigned v_total(vga_timing_t t);
      return t.active + t.front + t.sync + t.back;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source handshake: the generator publishes the raster position and
// strobes, and the source returns colour data for the requested pixel.
interface vga_timing_gen_if #(
   parameter int unsigned COLOR_W = 1,
   parameter int unsigned X_W     = 11,
   parameter int unsigned Y_W     = 10
);
   logic [X_W-1:0]     pix_x;
   logic [Y_W-1:0]     pix_y;
   logic               pix_req;
   logic               line_start;
   logic               frame_start;
   logic [COLOR_W-1:0] pix_r;
   logic [COLOR_W-1:0] pix_g;
   logic [COLOR_W-1:0] pix_b;

   modport master (
      output pix_x, pix_y, pix_req, line_start, frame_start,
      input  pix_r, pix_g, pix_b
   );

   modport slave (
      input  pix_x, pix_y, pix_req, line_start, frame_start,
      output pix_r, pix_g, pix_b
   );
endinterface

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register with synchronous clear; DEPTH=0 is a plain wire.
module vga_delay_line #(
   parameter int unsigned W     = 3,
   parameter int unsigned DEPTH = 1
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk_i ^ clr_i ^ en_i;
      assign q_o = d_i;
   end else begin : g_shift
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i) begin
         if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
         end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Configurable VGA raster generator: pixel-clock divider, h/v counters, sync
// windows, and a latency-matched output register for colour and syncs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = VGA_640X480_H.active,
   parameter int unsigned H_FRONT    = VGA_640X480_H.front,
   parameter int unsigned H_SYNC     = VGA_640X480_H.sync,
   parameter int unsigned H_BACK     = VGA_640X480_H.back,
   parameter int unsigned V_ACTIVE   = VGA_640X480_V.active,
   parameter int unsigned V_FRONT    = VGA_640X480_V.front,
   parameter int unsigned V_SYNC     = VGA_640X480_V.sync,
   parameter int unsigned V_BACK     = VGA_640X480_V.back,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0,
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned PIX_LAT    = 1,
   parameter int unsigned COLOR_W    = 1,
   parameter int unsigned X_W        = 11,
   parameter int unsigned Y_W        = 10
) (
   input  logic               clock,
   input  logic               reset,
   vga_timing_gen_if.master   pix_if,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               VGA_HSync,
   output logic               VGA_VSync
);

   localparam vga_timing_t H_T = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
   localparam vga_timing_t V_T = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
   localparam int unsigned H_TOTAL = h_total(H_T);
   localparam int unsigned V_TOTAL = v_total(V_T);

   if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..4");
   end
   if (PIX_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: PIX_LAT must be 0..4");
   end
   if (longint'(H_TOTAL) > (longint'(1) << X_W) || longint'(V_TOTAL) > (longint'(1) << Y_W)) begin : g_bad_w
      $error("vga_timing_gen: counter widths too small for totals");
   end
   if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
       V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_zero
      $error("vga_timing_gen: timing parameters must be non-zero");
   end

   localparam logic [1:0]     DIV_LAST = 2'(CLK_DIV - 1);
   localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACTIVE + H_FRONT);
   localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACTIVE + V_FRONT);
   localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [1:0]         div_q, div_d;
   logic [X_W-1:0]     h_q, h_d;
   logic [Y_W-1:0]     v_q, v_d;
   logic [COLOR_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
   logic               hs_q, hs_d, vs_q, vs_d;
   logic               tick, active, hs_raw, vs_raw;
   logic [2:0]         dly;

   assign tick   = (div_q == DIV_LAST);
   assign active = (h_q < H_ACT) && (v_q < V_ACT);
   assign hs_raw = (h_q >= HS_BEG) && (h_q < HS_END);
   assign vs_raw = (v_q >= VS_BEG) && (v_q < VS_END);

   always_comb begin
      div_d = tick ? 2'd0 : div_q + 2'd1;
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
         end else begin
            h_d = h_q + X_W'(1);
         end
      end
   end

   // Colour and syncs share one pipeline so they stay aligned for any PIX_LAT.
   vga_delay_line #(.W(3), .DEPTH(PIX_LAT)) u_dly (
      .clk_i (clock),
      .clr_i (reset),
      .en_i  (tick),
      .d_i   ({active, hs_raw, vs_raw}),
      .q_o   (dly)
   );

   always_comb begin
      vga_r_d = vga_r_q;
      vga_g_d = vga_g_q;
      vga_b_d = vga_b_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      if (tick) begin
         vga_r_d = dly[2] ? pix_if.pix_r : '0;
         vga_g_d = dly[2] ? pix_if.pix_g : '0;
         vga_b_d = dly[2] ? pix_if.pix_b : '0;
         hs_d    = dly[1] ~^ H_SYNC_POL;
         vs_d    = dly[0] ~^ V_SYNC_POL;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         vga_r_q <= '0;
         vga_g_q <= '0;
         vga_b_q <= '0;
         hs_q    <= ~H_SYNC_POL;
         vs_q    <= ~V_SYNC_POL;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         vga_r_q <= vga_r_d;
         vga_g_q <= vga_g_d;
         vga_b_q <= vga_b_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
      end
   end

   assign pix_if.pix_x       = h_q;
   assign pix_if.pix_y       = v_q;
   assign pix_if.pix_req     = tick & active & ~reset;
   assign pix_if.line_start  = tick & (h_q == '0) & ~reset;
   assign pix_if.frame_start = tick & (h_q == '0) & (v_q == '0) & ~reset;

   assign vga_r     = vga_r_q;
   assign vga_g     = vga_g_q;
   assign vga_b     = vga_b_q;
   assign VGA_HSync = hs_q;
   assign VGA_VSync = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two small-raster instances (H 8/2/2/2, V 4/1/1/1): A with CLK_DIV=2, PIX_LAT=2,
// mixed sync polarity; B with CLK_DIV=1, PIX_LAT=0 and opposite polarities.
module tb_vga_timing_gen;

   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FR = HT * VT;

   logic clk = 1'b0;
   logic rst;
   bit   in_rst;
   int   c;
   int   tests, fails;
   int   a_req_n, a_hs_n, a_vs_n, a_fs_n, a_ls_n;
   int   b_req_n, b_hs_n, b_vs_n, b_fs_n, b_ls_n;

   logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
   logic       a_hs, a_vs, b_hs, b_vs;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.COLOR_W(4), .X_W(5), .Y_W(4)) a_if ();
   vga_timing_gen_if #(.COLOR_W(4), .X_W(5), .Y_W(4)) b_if ();

   // Sources: A answers two ticks late, so it reports the pixel two columns back.
   assign a_if.pix_r = 4'(a_if.pix_x - 5'd2);
   assign a_if.pix_g = 4'(a_if.pix_y);
   assign a_if.pix_b = ~a_if.pix_r;
   assign b_if.pix_r = 4'(b_if.pix_x);
   assign b_if.pix_g = 4'(b_if.pix_y);
   assign b_if.pix_b = ~b_if.pix_r;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .CLK_DIV(2), .PIX_LAT(2),
      .COLOR_W(4), .X_W(5), .Y_W(4)
   ) u_a (
      .clock(clk), .reset(rst), .pix_if(a_if),
      .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .VGA_HSync(a_hs), .VGA_VSync(a_vs)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CLK_DIV(1), .PIX_LAT(0),
      .COLOR_W(4), .X_W(5), .Y_W(4)
   ) u_b (
      .clock(clk), .reset(rst), .pix_if(b_if),
      .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .VGA_HSync(b_hs), .VGA_VSync(b_vs)
   );

   function automatic int hpos(int p); return p % HT; endfunction
   function automatic int vpos(int p); return (p / HT) % VT; endfunction
   function automatic bit act(int p); return hpos(p) < 8 && vpos(p) < 4; endfunction
   function automatic bit hsr(int p); return hpos(p) >= 10 && hpos(p) < 12; endfunction
   function automatic bit vsr(int p); return vpos(p) == 5; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   // Expected values from the tick count since reset: the pins show the pixel
   // requested lat+1 ticks earlier, or reset levels before that.
   task automatic check_dut(input string nm, input int dv, input int lat,
                            input bit hpol, input bit vpol,
                            input logic [4:0] px, input logic [3:0] py,
                            input logic req, input logic ls, input logic fs,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic hs, input logic vs);
      int n, p, q;
      bit tk;
      logic [3:0] e_r, e_g, e_b;
      logic e_hs, e_vs;
      n  = in_rst ? 0 : c / dv;
      tk = !in_rst && (c % dv == dv - 1);
      p  = n % FR;
      e_r = '0; e_g = '0; e_b = '0;
      e_hs = ~hpol;
      e_vs = ~vpol;
      if (n >= lat + 1) begin
         q = (n - lat - 1) % FR;
         if (act(q)) begin
            e_r = 4'(hpos(q));
            e_g = 4'(vpos(q));
            e_b = ~e_r;
         end
         e_hs = hsr(q) ~^ hpol;
         e_vs = vsr(q) ~^ vpol;
      end
      chk({nm, "_pix_x"}, 32'(px), 32'(hpos(p)));
      chk({nm, "_pix_y"}, 32'(py), 32'(vpos(p)));
      chk({nm, "_pix_req"}, 32'(req), 32'(tk && act(p)));
      chk({nm, "_line_start"}, 32'(ls), 32'(tk && hpos(p) == 0));
      chk({nm, "_frame_start"}, 32'(fs), 32'(tk && p == 0));
      chk({nm, "_vga_r"}, 32'(r), 32'(e_r));
      chk({nm, "_vga_g"}, 32'(g), 32'(e_g));
      chk({nm, "_vga_b"}, 32'(b), 32'(e_b));
      chk({nm, "_hsync"}, 32'(hs), 32'(e_hs));
      chk({nm, "_vsync"}, 32'(vs), 32'(e_vs));
   endtask

   task automatic check_both();
      check_dut("a", 2, 2, 1'b0, 1'b1, a_if.pix_x, a_if.pix_y, a_if.pix_req,
                a_if.line_start, a_if.frame_start, a_r, a_g, a_b, a_hs, a_vs);
      check_dut("b", 1, 0, 1'b1, 1'b0, b_if.pix_x, b_if.pix_y, b_if.pix_req,
                b_if.line_start, b_if.frame_start, b_r, b_g, b_b, b_hs, b_vs);
   endtask

   task automatic hold_reset(input int ncyc);
      rst = 1'b1;
      in_rst = 1'b1;
      c = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_both();
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_rst = 1'b0;
      c = 0;
   endtask

   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         check_both();
         if (c == 0) begin
            chk("b_first_frame_start", 32'(b_if.frame_start), 32'd1);
            chk("b_first_line_start", 32'(b_if.line_start), 32'd1);
            chk("b_first_pix_req", 32'(b_if.pix_req), 32'd1);
            chk("a_no_tick_yet", 32'(a_if.frame_start), 32'd0);
         end
         if (c == 1) begin
            chk("a_first_frame_start", 32'(a_if.frame_start), 32'd1);
            chk("a_first_pix_req", 32'(a_if.pix_req), 32'd1);
         end
         if (c == 97) begin
            chk("b_wrap_last_x", 32'(b_if.pix_x), 32'd13);
            chk("b_wrap_last_y", 32'(b_if.pix_y), 32'd6);
         end
         if (c == 98) begin
            chk("b_wrap_x", 32'(b_if.pix_x), 32'd0);
            chk("b_wrap_y", 32'(b_if.pix_y), 32'd0);
            chk("b_wrap_fs", 32'(b_if.frame_start), 32'd1);
            chk("b_wrap_ls", 32'(b_if.line_start), 32'd1);
         end
         if (c == 195) begin
            chk("a_wrap_last_x", 32'(a_if.pix_x), 32'd13);
            chk("a_wrap_last_y", 32'(a_if.pix_y), 32'd6);
         end
         if (c == 197) begin
            chk("a_wrap_fs", 32'(a_if.frame_start), 32'd1);
            chk("a_wrap_ls", 32'(a_if.line_start), 32'd1);
         end
         if (c >= 196 && c < 392) begin
            a_req_n += int'(a_if.pix_req);
            a_hs_n  += int'(a_hs == 1'b0);
            a_vs_n  += int'(a_vs == 1'b1);
            a_fs_n  += int'(a_if.frame_start);
            a_ls_n  += int'(a_if.line_start);
         end
         if (c >= 98 && c < 196) begin
            b_req_n += int'(b_if.pix_req);
            b_hs_n  += int'(b_hs == 1'b1);
            b_vs_n  += int'(b_vs == 1'b0);
            b_fs_n  += int'(b_if.frame_start);
            b_ls_n  += int'(b_if.line_start);
         end
         c++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_rst = 1'b1;
      c = 0;
      tests = 0;
      fails = 0;
      a_req_n = 0; a_hs_n = 0; a_vs_n = 0; a_fs_n = 0; a_ls_n = 0;
      b_req_n = 0; b_hs_n = 0; b_vs_n = 0; b_fs_n = 0; b_ls_n = 0;

      hold_reset(3);
      run(392);

      // One full frame per instance: 32 active pixels, 2-pixel hsync per line,
      // one vsync line; A holds every tick for two clocks.
      chk("a_frame_req_count", 32'(a_req_n), 32'd32);
      chk("a_frame_hsync_clocks", 32'(a_hs_n), 32'd28);
      chk("a_frame_vsync_clocks", 32'(a_vs_n), 32'd28);
      chk("a_frame_fs_count", 32'(a_fs_n), 32'd1);
      chk("a_frame_ls_count", 32'(a_ls_n), 32'd7);
      chk("b_frame_req_count", 32'(b_req_n), 32'd32);
      chk("b_frame_hsync_clocks", 32'(b_hs_n), 32'd14);
      chk("b_frame_vsync_clocks", 32'(b_vs_n), 32'd14);
      chk("b_frame_fs_count", 32'(b_fs_n), 32'd1);
      chk("b_frame_ls_count", 32'(b_ls_n), 32'd7);

      run(60);
      hold_reset(3);
      run(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
